// File: rtl/tc26_timer_if.sv
// Register/status bus of the tc26 timer, including the all-ones feedback from the nd26 detector.
interface tc26_timer_if #(
  parameter int unsigned CNT_W = 26
);
  logic [CNT_W-1:0] din;
  logic             ld_wr;
  logic             ctl_wr;
  logic             irq_ack;
  logic             allones_n;
  logic [CNT_W-1:0] cnt_q;
  logic             irq;
  logic             ovr;
  logic             running;

  modport master (
    output din, ld_wr, ctl_wr, irq_ack, allones_n,
    input  cnt_q, irq, ovr, running
  );

  modport slave (
    input  din, ld_wr, ctl_wr, irq_ack, allones_n,
    output cnt_q, irq, ovr, running
  );
endinterface

// File: rtl/tc26_timer.sv
// 26-bit prescaled up-counting timer; terminal count is signalled back by the nd26 all-ones
// detector through allones_n, after which the counter reloads and raises a level interrupt.
module tc26_timer #(
  parameter int unsigned PRE_W = 8,
  parameter int unsigned CNT_W = 26
) (
  input logic         clk,
  input logic         reset,
  tc26_timer_if.slave bus
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [PRE_W-1:0]   precnt_q, precnt_d;
  logic [PRE_W-1:0]   prescale_q, prescale_d;
  logic               ien_q, ien_d;
  logic               oneshot_q, oneshot_d;
  logic               irq_pend_q, irq_pend_d;
  logic               ovr_q, ovr_d;
  logic               tick;
  logic               expiry;

  // A load in the same cycle swallows the tick so the written value is not bumped.
  assign tick   = (state_q == StRun) && (precnt_q == '0) && !bus.ld_wr;
  assign expiry = tick && !bus.allones_n;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.ctl_wr && bus.din[0]) state_d = StRun;
      StRun: begin
        if (bus.ctl_wr) begin
          if (!bus.din[0]) state_d = StIdle;
        end else if (expiry && oneshot_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    reload_d   = reload_q;
    precnt_d   = precnt_q;
    prescale_d = prescale_q;
    ien_d      = ien_q;
    oneshot_d  = oneshot_q;
    irq_pend_d = irq_pend_q;
    ovr_d      = ovr_q;

    if (bus.ctl_wr) begin
      oneshot_d  = bus.din[1];
      ien_d      = bus.din[2];
      prescale_d = bus.din[3 +: PRE_W];
      precnt_d   = bus.din[3 +: PRE_W];
    end else if (bus.ld_wr || state_q == StIdle || precnt_q == '0) begin
      precnt_d = prescale_q;
    end else begin
      precnt_d = precnt_q - PRE_W'(1);
    end

    if (bus.ld_wr) begin
      cnt_d    = bus.din;
      reload_d = bus.din;
    end else if (tick) begin
      cnt_d = bus.allones_n ? cnt_q + CNT_W'(1) : reload_q;
    end

    // Expiry wins over a coincident acknowledge; overrun only when the old one was never acked.
    if (expiry) begin
      irq_pend_d = 1'b1;
      if (irq_pend_q && !bus.irq_ack) ovr_d = 1'b1;
    end else if (bus.irq_ack) begin
      irq_pend_d = 1'b0;
      ovr_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      reload_q   <= '0;
      precnt_q   <= '0;
      prescale_q <= '0;
      ien_q      <= 1'b0;
      oneshot_q  <= 1'b0;
      irq_pend_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      reload_q   <= reload_d;
      precnt_q   <= precnt_d;
      prescale_q <= prescale_d;
      ien_q      <= ien_d;
      oneshot_q  <= oneshot_d;
      irq_pend_q <= irq_pend_d;
      ovr_q      <= ovr_d;
    end
  end

  assign bus.cnt_q   = cnt_q;
  assign bus.irq     = irq_pend_q & ien_q;
  assign bus.ovr     = ovr_q;
  assign bus.running = (state_q == StRun);

endmodule

// File: tb/tb_tc26_timer.sv
// Directed bench for tc26_timer; the nd26 detector is modelled as a NAND reduction of cnt_q.
module tb_tc26_timer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  tc26_timer_if #(.CNT_W(26)) bus ();

  tc26_timer #(.PRE_W(8), .CNT_W(26)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.allones_n = ~&bus.cnt_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.din     = '0;
    bus.ld_wr   = 1'b0;
    bus.ctl_wr  = 1'b0;
    bus.irq_ack = 1'b0;
    cyc();
    reset = 1'b0;
  endtask

  task automatic do_ld(input logic [25:0] v);
    bus.din   = v;
    bus.ld_wr = 1'b1;
    cyc();
    bus.ld_wr = 1'b0;
  endtask

  task automatic do_ctl(input logic [25:0] v);
    bus.din    = v;
    bus.ctl_wr = 1'b1;
    cyc();
    bus.ctl_wr = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.cnt_q !== 26'd0 || bus.running !== 1'b0 || bus.irq !== 1'b0 || bus.ovr !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: cnt=%h run=%b irq=%b ovr=%b, want all 0",
               bus.cnt_q, bus.running, bus.irq, bus.ovr);
    end
    do_ld(26'd120);
    do_ctl(26'd1);
    repeat (3) cyc();
    n_checks++;
    if (bus.cnt_q !== 26'd123 || bus.running !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_precount: cnt=%0d run=%b, want 123 1", bus.cnt_q, bus.running);
    end
    #3;
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.cnt_q !== 26'd0 || bus.running !== 1'b0 || bus.irq !== 1'b0 || bus.ovr !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_async: cnt=%h run=%b irq=%b ovr=%b, want all 0",
               bus.cnt_q, bus.running, bus.irq, bus.ovr);
    end
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_autoreload();
    logic [25:0] exp_cnt [4];
    exp_cnt[0] = 26'h3FFFFFD;
    exp_cnt[1] = 26'h3FFFFFE;
    exp_cnt[2] = 26'h3FFFFFF;
    exp_cnt[3] = 26'h3FFFFFC;
    do_reset();
    do_ld(26'h3FFFFFC);
    do_ctl(26'd5);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) begin
        cyc();
        n_checks++;
        if (bus.cnt_q !== exp_cnt[i]) begin
          n_errors++;
          $display("FAIL autoreload_cnt[%0d.%0d]: cnt=%h, want %h", r, i, bus.cnt_q, exp_cnt[i]);
        end
        if (r == 0) begin
          n_checks++;
          if (bus.irq !== (i == 3)) begin
            n_errors++;
            $display("FAIL autoreload_irq[%0d]: irq=%b, want %b", i, bus.irq, i == 3);
          end
        end
      end
    end
  endtask

  task automatic test_prescale();
    do_reset();
    do_ld(26'd0);
    do_ctl(26'd25);  // run, prescale=3
    repeat (3) cyc();
    n_checks++;
    if (bus.cnt_q !== 26'd0) begin
      n_errors++;
      $display("FAIL prescale_3clk: cnt=%0d, want 0", bus.cnt_q);
    end
    cyc();
    n_checks++;
    if (bus.cnt_q !== 26'd1) begin
      n_errors++;
      $display("FAIL prescale_4clk: cnt=%0d, want 1", bus.cnt_q);
    end
    repeat (4) cyc();
    n_checks++;
    if (bus.cnt_q !== 26'd2) begin
      n_errors++;
      $display("FAIL prescale_8clk: cnt=%0d, want 2", bus.cnt_q);
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    do_ld(26'h3FFFFFF);
    do_ctl(26'd7);
    n_checks++;
    if (bus.running !== 1'b1) begin
      n_errors++;
      $display("FAIL oneshot_start: running=%b, want 1", bus.running);
    end
    cyc();
    n_checks++;
    if (bus.cnt_q !== 26'h3FFFFFF || bus.running !== 1'b0 || bus.irq !== 1'b1) begin
      n_errors++;
      $display("FAIL oneshot_expiry: cnt=%h run=%b irq=%b, want 3ffffff 0 1",
               bus.cnt_q, bus.running, bus.irq);
    end
    repeat (3) cyc();
    n_checks++;
    if (bus.cnt_q !== 26'h3FFFFFF || bus.running !== 1'b0) begin
      n_errors++;
      $display("FAIL oneshot_hold: cnt=%h run=%b, want 3ffffff 0", bus.cnt_q, bus.running);
    end
  endtask

  task automatic test_overrun_ack();
    do_reset();
    do_ld(26'h3FFFFFF);
    do_ctl(26'd5);
    cyc();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.ovr !== 1'b0) begin
      n_errors++;
      $display("FAIL ovr_first: irq=%b ovr=%b, want 1 0", bus.irq, bus.ovr);
    end
    cyc();
    n_checks++;
    if (bus.ovr !== 1'b1) begin
      n_errors++;
      $display("FAIL ovr_second: ovr=%b, want 1", bus.ovr);
    end
    do_ctl(26'd4);
    bus.irq_ack = 1'b1;
    cyc();
    bus.irq_ack = 1'b0;
    n_checks++;
    if (bus.irq !== 1'b0 || bus.ovr !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_clear: irq=%b ovr=%b, want 0 0", bus.irq, bus.ovr);
    end
    do_ctl(26'd5);
    bus.irq_ack = 1'b1;
    cyc();
    n_checks++;
    if (bus.irq !== 1'b1 || bus.ovr !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_vs_expiry: irq=%b ovr=%b, want 1 0", bus.irq, bus.ovr);
    end
    cyc();
    bus.irq_ack = 1'b0;
    n_checks++;
    if (bus.irq !== 1'b1 || bus.ovr !== 1'b0) begin
      n_errors++;
      $display("FAIL ack_vs_expiry_pend: irq=%b ovr=%b, want 1 0", bus.irq, bus.ovr);
    end
  endtask

  task automatic test_ld_tick_mask();
    do_reset();
    do_ld(26'd100);
    do_ctl(26'd1);
    do_ld(26'd5);
    n_checks++;
    if (bus.cnt_q !== 26'd5) begin
      n_errors++;
      $display("FAIL ld_drops_tick: cnt=%0d, want 5", bus.cnt_q);
    end
    cyc();
    n_checks++;
    if (bus.cnt_q !== 26'd6) begin
      n_errors++;
      $display("FAIL ld_then_count: cnt=%0d, want 6", bus.cnt_q);
    end
    do_reset();
    do_ld(26'h3FFFFFF);
    do_ctl(26'd1);
    cyc();
    n_checks++;
    if (bus.irq !== 1'b0 || bus.running !== 1'b1 || bus.cnt_q !== 26'h3FFFFFF) begin
      n_errors++;
      $display("FAIL ien_masked: irq=%b run=%b cnt=%h, want 0 1 3ffffff",
               bus.irq, bus.running, bus.cnt_q);
    end
    do_ctl(26'd4);
    n_checks++;
    if (bus.irq !== 1'b1) begin
      n_errors++;
      $display("FAIL ien_unmask: irq=%b, want 1", bus.irq);
    end
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    reset       = 1'b1;
    bus.din     = '0;
    bus.ld_wr   = 1'b0;
    bus.ctl_wr  = 1'b0;
    bus.irq_ack = 1'b0;
    test_reset();
    test_autoreload();
    test_prescale();
    test_oneshot();
    test_overrun_ack();
    test_ld_tick_mask();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
